// File: rtl/mmio_port_ctrl.sv
// mmio_port_ctrl: a memory-mapped I/O port block on the processor bus.
// It has NUM_IN synchronised input channels. Each channel has sticky
// read-to-clear change flags, and the flags can raise an interrupt.
// It also has NUM_OUT read/write output registers and an IRQ enable word.
// Every accepted access is acknowledged with a single-cycle oRdy pulse.
//
// Word map, relative to BASE_ADDR, one 32-bit word every 4 bytes:
//   0 .. NUM_IN-1                    IN[k]   synchronised input, read-only
//   NUM_IN .. 2*NUM_IN-1             CHG[k]  change flags, read-to-clear
//   2*NUM_IN .. 2*NUM_IN+NUM_OUT-1   OUT[j]  output registers, read/write
//   2*NUM_IN+NUM_OUT                 IRQ_EN  one enable bit per input channel
module mmio_port_ctrl #(
  parameter int                NUM_IN    = 2,
  parameter int                NUM_OUT   = 2,
  parameter int                DATA_W    = 32,
  parameter logic [31:0]       BASE_ADDR = 32'hFFFF_FF00,
  parameter logic [DATA_W-1:0] OUT_RST   = '0
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [31:0]               iAddr,
  input  logic [DATA_W-1:0]         iData,
  input  logic                      iRead,
  input  logic                      iWrite,
  output logic [DATA_W-1:0]         oData,
  output logic                      oRdy,
  output logic                      oHit,
  input  logic [NUM_IN*DATA_W-1:0]  iPort,
  output logic [NUM_OUT*DATA_W-1:0] oPort,
  output logic                      oIrq
);

  localparam int          NUM_WORDS = 2*NUM_IN + NUM_OUT + 1;
  localparam int          IDX_W     = $clog2(NUM_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(4*NUM_WORDS);
  localparam int          CHG_BASE  = NUM_IN;
  localparam int          OUT_BASE  = 2*NUM_IN;
  localparam int          IRQ_WORD  = NUM_WORDS - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESP,
    S_WAIT
  } state_t;

  state_t state, next_state;
  logic   accept;
  logic   rd_acc;
  logic   wr_acc;

  // Address decode.
  logic [31:0]      offset;
  logic [IDX_W-1:0] word_idx;

  // Input path: two synchroniser stages, then a "previous" stage for edge detection.
  logic [DATA_W-1:0] sync1 [NUM_IN];
  logic [DATA_W-1:0] sync2 [NUM_IN];
  logic [DATA_W-1:0] prev  [NUM_IN];
  logic [DATA_W-1:0] chg   [NUM_IN];
  logic [DATA_W-1:0] chg_next [NUM_IN];
  logic [NUM_IN-1:0] chg_clr;
  logic [NUM_IN-1:0] chg_any;
  logic [1:0]        prime_cnt;
  logic              primed;

  // Software-visible registers.
  logic [DATA_W-1:0] out_reg [NUM_OUT];
  logic [NUM_IN-1:0] irq_en;
  logic [DATA_W-1:0] rd_data;

  // The subtraction keeps the window check free of overflow. This matters
  // when the window ends exactly at the top of the address space.
  assign offset   = iAddr - BASE_ADDR;
  assign word_idx = offset[IDX_W+1:2];
  assign oHit     = (iAddr[1:0] == 2'b00) && (iAddr >= BASE_ADDR) && (offset < WIN_BYTES);

  // State register of the bus handshake FSM.
  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples values from before the edge, whatever the order of the blocks.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next state and the accept strobe. A request level is one access only:
  // after RESP the FSM waits in WAIT until both request lines drop.
  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if ((iRead || iWrite) && oHit) begin
          accept     = 1'b1;
          next_state = S_RESP;
        end
      end
      S_RESP:  next_state = S_WAIT;
      S_WAIT:  if (!iRead && !iWrite) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // When a request is both a read and a write, the write wins. A read side
  // effect (CHG clear, oData update) happens only on a pure read.
  assign wr_acc = accept && iWrite;
  assign rd_acc = accept && iRead && !iWrite;

  // oRdy is decoded from the state register. An asynchronous reset
  // therefore removes it at once.
  assign oRdy = (state == S_RESP);

  // Input synchronisers, edge-detect stage and reset prime counter.
  // NOTE: these are small register arrays and not RAM, so every entry is
  // reset explicitly.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        sync1[i] <= '0;
        sync2[i] <= '0;
        prev[i]  <= '0;
      end
      prime_cnt <= 2'd0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        sync1[i] <= iPort[i*DATA_W +: DATA_W];
        sync2[i] <= sync1[i];
        prev[i]  <= sync2[i];
      end
      if (prime_cnt != 2'd3) prime_cnt <= prime_cnt + 2'd1;
    end
  end

  // The pipeline fills from reset zeros during the first three clocks after
  // release. Flag updates stay blocked until that is over.
  assign primed = (prime_cnt == 2'd3);

  // Next value of the change flags. A read of a CHG word clears the whole
  // word. A change arriving on that same edge is ORed in after the clear,
  // so the new bit survives.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      chg_clr[i]  = rd_acc && (word_idx == IDX_W'(CHG_BASE + i));
      chg_next[i] = chg[i] & {DATA_W{~chg_clr[i]}};
      if (primed) chg_next[i] = chg_next[i] | (sync2[i] ^ prev[i]);
      chg_any[i]  = |chg[i];
    end
  end

  // Sticky change-flag registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < NUM_IN; i++) chg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) chg[i] <= chg_next[i];
    end
  end

  // Output registers and interrupt enables. They are written at the
  // accepting edge. Writes to IN or CHG words fall through and are ignored.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int j = 0; j < NUM_OUT; j++) out_reg[j] <= OUT_RST;
      irq_en <= '0;
    end else if (wr_acc) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (word_idx == IDX_W'(OUT_BASE + j)) out_reg[j] <= iData;
      end
      if (word_idx == IDX_W'(IRQ_WORD)) irq_en <= iData[NUM_IN-1:0];
    end
  end

  // Read multiplexer. The CHG value returned is the value before the clear.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (word_idx == IDX_W'(i))            rd_data = sync2[i];
      if (word_idx == IDX_W'(CHG_BASE + i)) rd_data = chg[i];
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      if (word_idx == IDX_W'(OUT_BASE + j)) rd_data = out_reg[j];
    end
    if (word_idx == IDX_W'(IRQ_WORD)) begin
      rd_data               = '0;
      rd_data[NUM_IN-1:0]   = irq_en;
    end
  end

  // Read data register. It holds its value until the next accepted pure read.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)        oData <= '0;
    else if (rd_acc) oData <= rd_data;
  end

  // Interrupt register. It is set while any enabled channel has a pending flag.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) oIrq <= 1'b0;
    else      oIrq <= |(irq_en & chg_any);
  end

  // Concatenate the output registers onto the oPort bus.
  always_comb begin
    oPort = '0;
    for (int j = 0; j < NUM_OUT; j++) oPort[j*DATA_W +: DATA_W] = out_reg[j];
  end

endmodule

// File: doc/mmio_port_ctrl.md
Name: mmio_port_ctrl

Overview:
- Parametrised memory-mapped I/O port controller on the processor memory bus; the next generation of the single fixed input/output port pair.
- Provides NUM_IN synchronised input channels with sticky change flags and an interrupt, plus NUM_OUT read/write output registers.
- Decodes a word-aligned window at BASE_ADDR and acknowledges each access with a one-cycle ready pulse.
- Sits beside the MMU; the top level steers memory reads to it on oHit.

Parameters:
- NUM_IN, 2, number of input channels (1..8).
- NUM_OUT, 2, number of output registers (1..8).
- DATA_W, 32, width of every channel, register and bus data word.
- BASE_ADDR, 32'hFFFF_FF00, byte address of word 0; 4-byte aligned.
- OUT_RST, 0, reset value of every output register.

Ports:
- iClk  in  1  system clock; all state on rising edge.
- iRst  in  1  asynchronous reset, active-high.
- iAddr  in  32  byte address.
- iData  in  DATA_W  write data.
- iRead  in  1  read request level.
- iWrite  in  1  write request level.
- oData  out  DATA_W  read data; registered.
- oRdy  out  1  one-cycle acknowledge.
- oHit  out  1  combinational: iAddr is inside the window and word-aligned.
- iPort  in  NUM_IN*DATA_W  raw asynchronous inputs; channel i is bits [i*DATA_W +: DATA_W].
- oPort  out  NUM_OUT*DATA_W  output registers, concatenated the same way.
- oIrq  out  1  interrupt level.

Behaviour:
- Word map, offset = 4*k:
  - k = 0..NUM_IN-1: IN[k], read-only, synchronised input value.
  - k = NUM_IN..2*NUM_IN-1: CHG[k-NUM_IN], read-to-clear. Bit set means the input bit changed since the last read.
  - next NUM_OUT words: OUT[j], read/write.
  - last word: IRQ_EN, NUM_IN bits, read/write; the rest reads 0.
  - Total W = 2*NUM_IN+NUM_OUT+1 words.
- oHit is 1 only when iAddr[1:0]==0 and BASE_ADDR <= iAddr < BASE_ADDR+4*W. Misaligned or out-of-window addresses get no acknowledge.
- Writes to IN or CHG words are acknowledged and have no effect.
- Synchroniser: 2 flip-flop stages per bit, then a "previous" stage. A bit change sets the matching CHG bit (sticky).
- Reset priming: a 2-bit prime counter holds CHG updates off for the first 3 clocks after iRst deasserts, so reset-release transitions never set flags.
- FSM states:
  - IDLE: a request (iRead|iWrite) with oHit is accepted. If both iRead and iWrite are high, the write wins and no read side effects occur. Go to RESP.
  - RESP: oRdy=1 for exactly this cycle; oData holds the read result (unchanged on a write). Go to WAIT.
  - WAIT: stay until iRead==0 and iWrite==0, then go to IDLE.
  - Each request level is therefore exactly one access, so reads never clear CHG twice.
- A request without oHit keeps the FSM in IDLE.
- Latency: the write takes effect at the accepting edge; the read is sampled at the accepting edge; oRdy follows 1 cycle after acceptance.
- CHG read-to-clear happens at the accepting edge. If a new change occurs on that same edge, the new bit stays set (set wins over clear). The returned data is the pre-clear value.
- oData holds the last read value until the next accepted read.
- oIrq, registered: OR over i of (IRQ_EN[i] & |CHG[i]).
- Reset values:
  - oData=0, oRdy=0, oIrq=0, oPort all OUT_RST, IRQ_EN=0.
  - CHG=0, sync stages 0, FSM=IDLE.
- Reset asserted mid-access aborts the access; no pending oRdy follows reset release.
- No wrap-around: addresses past the last word miss, even if their low bits alias a valid word.

Test Plan:
- Defaults, after reset: write 0xDEADBEEF to 0xFFFF_FF14, then read it back.
  - oPort[63:32]=0xDEADBEEF.
  - Read returns 0xDEADBEEF with oRdy high for 1 cycle; oHit=1; oPort[31:0] stays 0.
- Hold iPort[31:0]=0x00000005 through reset release.
  - CHG0 at 0xFFFF_FF08 reads 0 (priming works).
  - IN0 at 0xFFFF_FF00 reads 0x00000005 after the sync delay.
- Toggle iPort bit 3, read 0xFFFF_FF08, then read again.
  - First read returns 0x00000008; second returns 0.
  - Hold iRead high 10 cycles: exactly one oRdy pulse, flag cleared once.
- Set IRQ_EN=0x2 at 0xFFFF_FF18, then toggle channel 0.
  - oIrq stays 0.
- Toggle channel 1 bit 0.
  - oIrq rises within 4 cycles.
  - After reading 0xFFFF_FF0C, oIrq falls the cycle after acknowledge.
- Corner cases on window and timing:
  - Read 0xFFFF_FF1C or 0xFFFF_FF02: oHit=0 and no oRdy for 5 cycles.
  - Input toggle on the same edge as a CHG read: flag remains set.
  - Assert iRst during RESP: oRdy=0 immediately; all outputs return to reset values.
